ahb_decoder_param: RTL and testbench
====================================

Name: ahb_decoder_param

Overview:
- Parametrised AHB address decoder, successor to the fixed three-slave decoder.
- Decodes HADDR into a one-hot address-phase select over NUM_SLAVES equal, contiguous regions starting at address 0.
- Registers a data-phase select copy that drives the read-data/response multiplexor.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for active transfers to unmapped addresses.

Parameters:
- ADDR_W, 32, HADDR width in bits.
- NUM_SLAVES, 3, number of decoded slaves; legal range 1..16.
- REGION_LOG2, 24, log2 of the region size in bytes. Default gives 16 MB per slave, so slave i covers [i<<24, (i+1)<<24).

Ports:
- HCLK  input  1  bus clock; all state updates on its rising edge.
- HRESETn  input  1  reset, synchronous, active-low.
- HADDR  input  ADDR_W  address-phase address.
- HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  input  1  global ready, as returned by the response multiplexor.
- HSEL  output  NUM_SLAVES  one-hot address-phase slave select.
- HSEL_Default  output  1  address-phase default-slave select.
- HSEL_D  output  NUM_SLAVES  registered data-phase slave select, for the multiplexor.
- HSEL_D_Default  output  1  registered data-phase default select.
- DEF_HREADYOUT  output  1  default-slave ready.
- DEF_HRESP  output  2  default-slave response: OKAY=00, ERROR=01.

Behaviour:
- Address decode is combinational.
  - idx = HADDR >> REGION_LOG2, compared at full width.
  - HSEL[i] = 1 iff idx == i and i < NUM_SLAVES.
  - HSEL_Default = 1 iff no HSEL bit is set, or HRESETn = 0.
  - While HRESETn = 0, HSEL is forced to all-zero. Decode ignores HTRANS.
- Exactly one of {HSEL bits, HSEL_Default} is high in every cycle.
- Address HADDR = (NUM_SLAVES << REGION_LOG2) - 1 belongs to the last slave. The next address goes to default. Any address with bits set above the decoded index width goes to default; upper address bits never alias onto a slave.
- Data-phase register:
  - On a clock edge with HRESETn = 0: HSEL_D <= 0 and HSEL_D_Default <= 1.
  - Else, if HREADY = 1: {HSEL_D, HSEL_D_Default} <= {HSEL, HSEL_Default}.
  - Else: hold. Latency is 1 cycle from address phase to data phase.
- Default-slave FSM has three states: IDLE, ERR1, ERR2.
  - IDLE: DEF_HREADYOUT = 1, DEF_HRESP = OKAY.
    - Go to ERR1 when HREADY = 1, HSEL_Default = 1 and HTRANS[1] = 1 (NONSEQ or SEQ). Otherwise stay in IDLE.
    - IDLE or BUSY transfers to unmapped space get a zero-wait OKAY.
  - ERR1: DEF_HREADYOUT = 0, DEF_HRESP = ERROR. Always go to ERR2 next cycle.
  - ERR2: DEF_HREADYOUT = 1, DEF_HRESP = ERROR.
    - If HREADY = 1, HSEL_Default = 1 and HTRANS[1] = 1: go to ERR1 (back-to-back errors).
    - Else: go to IDLE.
- Because HSEL_Default and HTRANS are sampled in ERR2, a master that cancels to IDLE in the second error cycle gets no further error.
- Reset:
  - Synchronous reset puts the FSM in IDLE, so DEF_HREADYOUT = 1 and DEF_HRESP = OKAY after the edge.
  - Reset asserted in ERR1 or ERR2 aborts the response at the next edge.
  - Outputs before the first reset edge are undefined.
- A transfer is sampled only when HREADY = 1. The decoder never stalls a mapped slave.

Test Plan:
- Reset: hold HRESETn = 0 for 2 cycles with HADDR = 0x0000_0000 -> HSEL = 000, HSEL_Default = 1, HSEL_D = 000, HSEL_D_Default = 1, DEF_HREADYOUT = 1, DEF_HRESP = 00.
- Boundaries (defaults), NONSEQ, HREADY = 1:
  - HADDR 0x00FF_FFFF -> HSEL = 001.
  - HADDR 0x0100_0000 -> HSEL = 010.
  - HADDR 0x02FF_FFFF -> HSEL = 100.
  - HADDR 0x0300_0000 -> HSEL_Default = 1.
  - HADDR 0xFF00_0000 -> HSEL_Default = 1.
  - HSEL_D follows each address one cycle later.
- Error response: NONSEQ to 0x0300_0000 with HREADY = 1 -> next cycle DEF_HREADYOUT = 0, DEF_HRESP = 01; following cycle DEF_HREADYOUT = 1, DEF_HRESP = 01; then 1/00 if HTRANS = IDLE.
- Back-to-back errors: NONSEQ to 0x0400_0000 issued during ERR2 -> sequence 0/01, 1/01, 0/01, 1/01. HTRANS = IDLE (00) to unmapped space -> stays 1/00.
- Stall: HREADY = 0 for 3 cycles while HADDR changes 0x0000_0000 -> 0x0100_0000 -> HSEL_D holds 001 until HREADY = 1, then updates to 010 on the next edge.
- Reset mid-response: drop HRESETn during ERR1 -> after the next edge DEF_HREADYOUT = 1, DEF_HRESP = 00, HSEL_D_Default = 1. Also recompile with NUM_SLAVES = 16, REGION_LOG2 = 12 -> 0x0000_F000 selects HSEL[15] and 0x0001_0000 selects default.

Source files
------------

// File: rtl/ahb_decoder_param.sv
// Parametrised AHB address decoder: one-hot slave select over NUM_SLAVES equal
// regions from address 0, a registered data-phase select, and a built-in default slave.
module ahb_decoder_param #(
    parameter int ADDR_W      = 32,
    parameter int NUM_SLAVES  = 3,
    parameter int REGION_LOG2 = 24
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_W-1:0]     HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [NUM_SLAVES-1:0] HSEL,
    output logic                  HSEL_Default,
    output logic [NUM_SLAVES-1:0] HSEL_D,
    output logic                  HSEL_D_Default,
    output logic                  DEF_HREADYOUT,
    output logic [1:0]            DEF_HRESP
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              err_req;
    logic              unused_htrans0;

    // Full-width compare so set bits above the index never alias onto a slave.
    assign idx = HADDR >> REGION_LOG2;

    always_comb begin
        HSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == ADDR_W'(i)) begin
                HSEL[i] = 1'b1;
            end
        end
        if (!HRESETn) begin
            HSEL = '0;
        end
    end

    assign HSEL_Default   = ~|HSEL;
    assign err_req        = HREADY & HSEL_Default & HTRANS[1];
    assign unused_htrans0 = HTRANS[0];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            HSEL_D         <= '0;
            HSEL_D_Default <= 1'b1;
        end else if (HREADY) begin
            HSEL_D         <= HSEL;
            HSEL_D_Default <= HSEL_Default;
        end
    end

    // Default slave: ERR1 (wait, ERROR) then ERR2 (ready, ERROR); outputs registered.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state         <= ST_IDLE;
            DEF_HREADYOUT <= 1'b1;
            DEF_HRESP     <= RESP_OKAY;
        end else begin
            case (state)
                ST_ERR1: begin
                    state         <= ST_ERR2;
                    DEF_HREADYOUT <= 1'b1;
                    DEF_HRESP     <= RESP_ERROR;
                end
                default: begin
                    if (err_req) begin
                        state         <= ST_ERR1;
                        DEF_HREADYOUT <= 1'b0;
                        DEF_HRESP     <= RESP_ERROR;
                    end else begin
                        state         <= ST_IDLE;
                        DEF_HREADYOUT <= 1'b1;
                        DEF_HRESP     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_decoder_param.sv
// Randomised bench for ahb_decoder_param: two configurations (3x16MB and 16x4KB)
// checked every cycle against an address-arithmetic model, plus directed literal checks.
module tb_ahb_decoder_param;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        ready;

    logic [2:0]  hsel0, hsel_d0;
    logic        def0, def_d0, rdy0;
    logic [1:0]  resp0;
    logic [15:0] hsel1, hsel_d1;
    logic        def1, def_d1, rdy1;
    logic [1:0]  resp1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state per configuration: data-phase slave (-1 = default) and
    // position within an error response (0 none, 1 first cycle, 2 second cycle).
    int m_d    [2];
    int m_step [2];

    always #5 clk = ~clk;

    ahb_decoder_param #(.ADDR_W(32), .NUM_SLAVES(3), .REGION_LOG2(24)) dut0 (
        .HCLK(clk), .HRESETn(rstn), .HADDR(addr), .HTRANS(trans), .HREADY(ready),
        .HSEL(hsel0), .HSEL_Default(def0), .HSEL_D(hsel_d0), .HSEL_D_Default(def_d0),
        .DEF_HREADYOUT(rdy0), .DEF_HRESP(resp0)
    );

    ahb_decoder_param #(.ADDR_W(32), .NUM_SLAVES(16), .REGION_LOG2(12)) dut1 (
        .HCLK(clk), .HRESETn(rstn), .HADDR(addr), .HTRANS(trans), .HREADY(ready),
        .HSEL(hsel1), .HSEL_Default(def1), .HSEL_D(hsel_d1), .HSEL_D_Default(def_d1),
        .DEF_HREADYOUT(rdy1), .DEF_HRESP(resp1)
    );

    function automatic int cfg_ns(int k);
        return (k == 0) ? 3 : 16;
    endfunction

    function automatic int cfg_rl(int k);
        return (k == 0) ? 24 : 12;
    endfunction

    // Slave number covering address a, or -1 when a lies beyond the mapped span.
    function automatic int region(logic [31:0] a, int k);
        logic [63:0] r;
        r = {32'd0, a} >> cfg_rl(k);
        if (r < 64'(cfg_ns(k))) return int'(r);
        return -1;
    endfunction

    function automatic logic [15:0] onehot(int s);
        logic [15:0] v;
        v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    function automatic int next_step(int step, int k);
        bit accept;
        accept = ready && trans[1] && (region(addr, k) < 0);
        if (step == 1) return 2;
        return accept ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                m_d[k]    <= -1;
                m_step[k] <= 0;
            end else begin
                if (ready) m_d[k] <= region(addr, k);
                m_step[k] <= next_step(m_step[k], k);
            end
        end
        if (!rstn) chk_en <= 1'b1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both configurations against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [15:0] e_sel, e_seld, a_sel, a_seld;
                logic        a_def, a_defd, a_rdy;
                logic [1:0]  a_resp;
                e_sel  = rstn ? onehot(region(addr, k)) : 16'd0;
                e_seld = onehot(m_d[k]);
                a_sel  = (k == 0) ? {13'd0, hsel0}   : hsel1;
                a_seld = (k == 0) ? {13'd0, hsel_d0} : hsel_d1;
                a_def  = (k == 0) ? def0   : def1;
                a_defd = (k == 0) ? def_d0 : def_d1;
                a_rdy  = (k == 0) ? rdy0   : rdy1;
                a_resp = (k == 0) ? resp0  : resp1;
                check($sformatf("model_hsel[%0d]", k), 32'(a_sel), 32'(e_sel));
                check($sformatf("model_hsel_def[%0d]", k), 32'(a_def), 32'(e_sel == 16'd0));
                check($sformatf("model_hsel_d[%0d]", k), 32'(a_seld), 32'(e_seld));
                check($sformatf("model_hsel_d_def[%0d]", k), 32'(a_defd), 32'(m_d[k] < 0));
                check($sformatf("model_readyout[%0d]", k), 32'(a_rdy), 32'(m_step[k] != 1));
                check($sformatf("model_resp[%0d]", k), 32'(a_resp), 32'(m_step[k] != 0));
            end
        end
    end

    task automatic apply(logic [31:0] a, logic [1:0] t, logic r, logic n);
        @(posedge clk);
        #1;
        addr  = a;
        trans = t;
        ready = r;
        rstn  = n;
        @(negedge clk);
    endtask

    task automatic lit_resp(string name, logic r, logic [1:0] p);
        check({name, "_rdy"}, 32'(rdy0), 32'(r));
        check({name, "_resp"}, 32'(resp0), 32'(p));
    endtask

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;

    initial begin
        logic [31:0] a;
        int          pick;
        addr  = '0;
        trans = T_IDLE;
        ready = 1'b1;
        rstn  = 1'b0;

        apply(32'h0000_0000, T_IDLE, 1'b1, 1'b0);
        apply(32'h0000_0000, T_IDLE, 1'b1, 1'b0);
        check("rst_hsel", 32'(hsel0), 32'h0);
        check("rst_hsel_def", 32'(def0), 32'h1);
        check("rst_hsel_d", 32'(hsel_d0), 32'h0);
        check("rst_hsel_d_def", 32'(def_d0), 32'h1);
        lit_resp("rst", 1'b1, 2'b00);

        apply(32'h00FF_FFFF, T_NSEQ, 1'b1, 1'b1);
        check("b0_hsel", 32'(hsel0), 32'h1);
        apply(32'h0100_0000, T_NSEQ, 1'b1, 1'b1);
        check("b1_hsel", 32'(hsel0), 32'h2);
        check("b1_hsel_d", 32'(hsel_d0), 32'h1);
        apply(32'h02FF_FFFF, T_NSEQ, 1'b1, 1'b1);
        check("b2_hsel", 32'(hsel0), 32'h4);
        check("b2_hsel_d", 32'(hsel_d0), 32'h2);
        apply(32'h0300_0000, T_NSEQ, 1'b1, 1'b1);
        check("b3_def", 32'(def0), 32'h1);
        check("b3_hsel_d", 32'(hsel_d0), 32'h4);
        lit_resp("b3", 1'b1, 2'b00);
        apply(32'hFF00_0000, T_IDLE, 1'b1, 1'b1);
        check("b4_def", 32'(def0), 32'h1);
        check("b4_hsel", 32'(hsel0), 32'h0);
        check("b4_hsel_d_def", 32'(def_d0), 32'h1);
        lit_resp("err1", 1'b0, 2'b01);
        apply(32'h0000_0000, T_IDLE, 1'b1, 1'b1);
        lit_resp("err2", 1'b1, 2'b01);
        apply(32'h0300_0000, T_NSEQ, 1'b1, 1'b1);
        lit_resp("err_done", 1'b1, 2'b00);

        apply(32'h0400_0000, T_IDLE, 1'b1, 1'b1);
        lit_resp("b2b_a", 1'b0, 2'b01);
        apply(32'h0400_0000, T_NSEQ, 1'b1, 1'b1);
        lit_resp("b2b_b", 1'b1, 2'b01);
        apply(32'h0300_0000, T_IDLE, 1'b1, 1'b1);
        lit_resp("b2b_c", 1'b0, 2'b01);
        apply(32'h0000_0000, T_IDLE, 1'b1, 1'b1);
        lit_resp("b2b_d", 1'b1, 2'b01);
        apply(32'h0300_0000, T_IDLE, 1'b1, 1'b1);
        lit_resp("idle_unmapped", 1'b1, 2'b00);
        apply(32'h0300_0000, T_BUSY, 1'b1, 1'b1);
        lit_resp("idle_unmapped2", 1'b1, 2'b00);
        apply(32'h0000_0000, T_NSEQ, 1'b1, 1'b1);
        lit_resp("busy_unmapped", 1'b1, 2'b00);

        for (int i = 0; i < 3; i++) begin
            apply(32'h0100_0000, T_NSEQ, 1'b0, 1'b1);
            check("stall_hold", 32'(hsel_d0), 32'h1);
        end
        apply(32'h0100_0000, T_NSEQ, 1'b1, 1'b1);
        check("stall_release", 32'(hsel_d0), 32'h1);
        apply(32'h0100_0000, T_IDLE, 1'b1, 1'b1);
        check("stall_update", 32'(hsel_d0), 32'h2);

        apply(32'h0300_0000, T_NSEQ, 1'b1, 1'b1);
        apply(32'h0000_0000, T_IDLE, 1'b1, 1'b0);
        lit_resp("mid_err1", 1'b0, 2'b01);
        check("mid_rst_hsel_def", 32'(def0), 32'h1);
        apply(32'h0000_0000, T_IDLE, 1'b1, 1'b1);
        lit_resp("mid_abort", 1'b1, 2'b00);
        check("mid_abort_d_def", 32'(def_d0), 32'h1);

        apply(32'h0000_F000, T_NSEQ, 1'b1, 1'b1);
        check("p16_top", 32'(hsel1), 32'h8000);
        apply(32'h0001_0000, T_NSEQ, 1'b1, 1'b1);
        check("p16_over_hsel", 32'(hsel1), 32'h0);
        check("p16_over_def", 32'(def1), 32'h1);
        check("p16_top_d", 32'(hsel_d1), 32'h8000);

        for (int i = 0; i < 3000; i++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: a = $urandom;
                1: a = ($urandom_range(0, 4) << 24) - 32'($urandom_range(0, 1));
                2: a = ($urandom_range(0, 17) << 12) - 32'($urandom_range(0, 1));
                3: a = {8'($urandom), 24'($urandom_range(0, 3))};
                4: a = 32'($urandom_range(0, 32'h0001_1000));
                default: a = 32'($urandom_range(0, 32'h0400_0000));
            endcase
            apply(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
